// File: rtl/render_pkg.sv
// Shared types and colour constants for the wireframe line renderer.
// LINE_COLOR_PROG_EN adds a programmable colour field to each segment record.
package render_pkg;

  localparam int SEG_CW = 12;

  localparam logic [11:0] BG_COLOR    = 12'h49C;
  localparam logic [11:0] BLANK_COLOR = 12'h000;

  localparam logic [11:0] PALETTE [6] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF
  };

  typedef struct packed {
    logic                     en;
    logic signed [SEG_CW-1:0] x0;
    logic signed [SEG_CW-1:0] y0;
    logic signed [SEG_CW-1:0] x1;
    logic signed [SEG_CW-1:0] y1;
`ifdef LINE_COLOR_PROG_EN
    logic [11:0]              color;
`endif
  } seg_t;

  function automatic logic [11:0] pal(input int i);
    logic [2:0] k;
    k = 3'(i % 6);
    return PALETTE[k];
  endfunction

endpackage

// File: rtl/line_hit_unit.sv
// Three-stage point-versus-segment test: deltas, cross product, threshold.
// Full-width arithmetic throughout, so no input can overflow.
module line_hit_unit
  import render_pkg::*;
#(
  parameter int COORD_W = 12,
  parameter int THICK   = 1
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic signed [COORD_W-1:0] x0_i,
  input  logic signed [COORD_W-1:0] y0_i,
  input  logic signed [COORD_W-1:0] x1_i,
  input  logic signed [COORD_W-1:0] y1_i,
  input  logic [9:0]                h_i,
  input  logic [9:0]                v_i,
  output logic                      hit_o
);

  localparam int W1 = COORD_W + 1;
  localparam int W2 = 2 * COORD_W + 3;
  localparam int WB = W1 + 3;

  typedef logic signed [W1-1:0] s1_t;

  localparam s1_t TK = s1_t'(THICK);

  s1_t x0e, y0e, x1e, y1e, he, ve;

  always_comb begin
    x0e = s1_t'(x0_i);
    y0e = s1_t'(y0_i);
    x1e = s1_t'(x1_i);
    y1e = s1_t'(y1_i);
    he  = s1_t'({1'b0, h_i});
    ve  = s1_t'({1'b0, v_i});
  end

  s1_t  dx_q, dy_q, px_q, py_q;
  s1_t  xlo_q, xhi_q, ylo_q, yhi_q;
  s1_t  hx_q, vy_q;
  logic en1_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      dx_q  <= '0;
      dy_q  <= '0;
      px_q  <= '0;
      py_q  <= '0;
      xlo_q <= '0;
      xhi_q <= '0;
      ylo_q <= '0;
      yhi_q <= '0;
      hx_q  <= '0;
      vy_q  <= '0;
      en1_q <= 1'b0;
    end else begin
      dx_q  <= x1e - x0e;
      dy_q  <= y1e - y0e;
      px_q  <= he - x0e;
      py_q  <= ve - y0e;
      xlo_q <= ((x0e < x1e) ? x0e : x1e) - TK;
      xhi_q <= ((x0e < x1e) ? x1e : x0e) + TK;
      ylo_q <= ((y0e < y1e) ? y0e : y1e) - TK;
      yhi_q <= ((y0e < y1e) ? y1e : y0e) + TK;
      hx_q  <= he;
      vy_q  <= ve;
      en1_q <= en_i;
    end
  end

  logic signed [W2-1:0] cross_d, cross_q;
  logic [W1-1:0]        adx, ady, amax;
  logic [WB-1:0]        bound_d, bound_q;
  logic                 in_d, in_q, en2_q;

  always_comb begin
    cross_d = W2'(dx_q) * W2'(py_q) - W2'(dy_q) * W2'(px_q);
    adx     = dx_q[W1-1] ? W1'(-dx_q) : W1'(dx_q);
    ady     = dy_q[W1-1] ? W1'(-dy_q) : W1'(dy_q);
    amax    = (adx > ady) ? adx : ady;
    bound_d = WB'(amax) * WB'(THICK);
    in_d    = (hx_q >= xlo_q) && (hx_q <= xhi_q) &&
              (vy_q >= ylo_q) && (vy_q <= yhi_q);
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cross_q <= '0;
      bound_q <= '0;
      in_q    <= 1'b0;
      en2_q   <= 1'b0;
    end else begin
      cross_q <= cross_d;
      bound_q <= bound_d;
      in_q    <= in_d;
      en2_q   <= en1_q;
    end
  end

  logic [W2-1:0] acr;
  logic          hit_q;

  assign acr = cross_q[W2-1] ? W2'(-cross_q) : W2'(cross_q);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= en2_q && in_q && (acr <= W2'(bound_q));
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/wireframe_line_renderer.sv
// Double-buffered segment banks feeding per-segment hit pipelines.
// LINE_COLOR_PROG_EN enables ld_color and per-segment colour registers.
module wireframe_line_renderer
  import render_pkg::*;
#(
  parameter int NUM_LINES = 6,
  parameter int COORD_W   = 12,
  parameter int THICK     = 1,
  parameter int IDX_W     = 4
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [9:0]                h_cnt,
  input  logic [9:0]                v_cnt,
  input  logic                      pix_valid,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [IDX_W-1:0]          ld_idx,
  input  logic                      ld_en,
  input  logic signed [COORD_W-1:0] ld_x0,
  input  logic signed [COORD_W-1:0] ld_y0,
  input  logic signed [COORD_W-1:0] ld_x1,
  input  logic signed [COORD_W-1:0] ld_y1,
`ifdef LINE_COLOR_PROG_EN
  input  logic [11:0]               ld_color,
`endif
  output logic [11:0]               vga_data,
  output logic                      vga_valid,
  output logic [NUM_LINES-1:0]      hit_vec,
  output logic                      bad_idx
);

  function automatic seg_t rst_seg(input int i);
    seg_t s;
    s = '0;
`ifdef LINE_COLOR_PROG_EN
    s.color = pal(i);
`endif
    return s;
  endfunction

  seg_t shadow_q [NUM_LINES];
  seg_t active_q [NUM_LINES];
  seg_t ld_seg;
  logic ld_fire, idx_ok, bad_q;

  assign ld_ready = !rst && !frame_start;
  assign ld_fire  = ld_valid && ld_ready;
  assign idx_ok   = {1'b0, ld_idx} < (IDX_W+1)'(NUM_LINES);

  always_comb begin
    ld_seg    = '0;
    ld_seg.en = ld_en;
    ld_seg.x0 = SEG_CW'(ld_x0);
    ld_seg.y0 = SEG_CW'(ld_y0);
    ld_seg.x1 = SEG_CW'(ld_x1);
    ld_seg.y1 = SEG_CW'(ld_y1);
`ifdef LINE_COLOR_PROG_EN
    ld_seg.color = ld_color;
`endif
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) shadow_q[i] <= rst_seg(i);
      bad_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++)
        if (ld_fire && ld_idx == IDX_W'(i)) shadow_q[i] <= ld_seg;
      if (ld_fire && !idx_ok) bad_q <= 1'b1;
    end
  end

  // Whole-bank copy; a pixel sampled on this edge still sees the old set.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) active_q[i] <= rst_seg(i);
    end else if (frame_start) begin
      for (int i = 0; i < NUM_LINES; i++) active_q[i] <= shadow_q[i];
    end
  end

  logic [NUM_LINES-1:0] hits;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    line_hit_unit #(
      .COORD_W (COORD_W),
      .THICK   (THICK)
    ) u_hit (
      .CLK   (CLK),
      .rst   (rst),
      .en_i  (active_q[g].en),
      .x0_i  (COORD_W'(active_q[g].x0)),
      .y0_i  (COORD_W'(active_q[g].y0)),
      .x1_i  (COORD_W'(active_q[g].x1)),
      .y1_i  (COORD_W'(active_q[g].y1)),
      .h_i   (h_cnt),
      .v_i   (v_cnt),
      .hit_o (hits[g])
    );
  end

  logic [2:0] vld_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[1:0], pix_valid};
  end

  logic [11:0] pick_color;

  always_comb begin
    pick_color = BG_COLOR;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (hits[i]) begin
`ifdef LINE_COLOR_PROG_EN
        pick_color = active_q[i].color;
`else
        pick_color = pal(i);
`endif
      end
    end
  end

  assign vga_valid = vld_q[2];
  assign vga_data  = vld_q[2] ? pick_color : BLANK_COLOR;
  assign hit_vec   = vld_q[2] ? hits : '0;
  assign bad_idx   = bad_q;

endmodule

// File: tb/tb_wireframe_line_renderer.sv
// Self-checking bench for wireframe_line_renderer (default parameters).
// Pixel expectations are queued at drive time and popped three cycles later.
module tb_wireframe_line_renderer;

  logic               CLK = 1'b0;
  logic               rst = 1'b1;
  logic               frame_start = 1'b0;
  logic [9:0]         h_cnt = '0;
  logic [9:0]         v_cnt = '0;
  logic               pix_valid = 1'b0;
  logic               ld_valid = 1'b0;
  logic               ld_ready;
  logic [3:0]         ld_idx = '0;
  logic               ld_en = 1'b0;
  logic signed [11:0] ld_x0 = '0;
  logic signed [11:0] ld_y0 = '0;
  logic signed [11:0] ld_x1 = '0;
  logic signed [11:0] ld_y1 = '0;
`ifdef LINE_COLOR_PROG_EN
  logic [11:0]        ld_color = '0;
`endif
  logic [11:0]        vga_data;
  logic               vga_valid;
  logic [5:0]         hit_vec;
  logic               bad_idx;

  wireframe_line_renderer #(
    .NUM_LINES (6),
    .COORD_W   (12),
    .THICK     (1),
    .IDX_W     (4)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .frame_start (frame_start),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .pix_valid   (pix_valid),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_idx      (ld_idx),
    .ld_en       (ld_en),
    .ld_x0       (ld_x0),
    .ld_y0       (ld_y0),
    .ld_x1       (ld_x1),
    .ld_y1       (ld_y1),
`ifdef LINE_COLOR_PROG_EN
    .ld_color    (ld_color),
`endif
    .vga_data    (vga_data),
    .vga_valid   (vga_valid),
    .hit_vec     (hit_vec),
    .bad_idx     (bad_idx)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          pv;
    logic [11:0] d;
    logic [5:0]  v;
    string       nm;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    bit          pv;
    logic [11:0] d;
    logic [5:0]  vec;
    string       nm;
  } vec_t;

  typedef struct {
    bit en;
    int x0, y0, x1, y1;
  } mseg_t;

  localparam logic [11:0] PAL [6] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF
  };

  exp_t  q[$];
  mseg_t m_sh [6];
  mseg_t m_act [6];
  int    n_tot = 0;
  int    n_pass = 0;
  bit    mon_en = 1'b0;

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic bit m_hit(input mseg_t s, input int h, input int v);
    int dx, dy, cr, mx;
    bit in;
    dx = s.x1 - s.x0;
    dy = s.y1 - s.y0;
    cr = dx * (v - s.y0) - dy * (h - s.x0);
    mx = (iabs(dx) > iabs(dy)) ? iabs(dx) : iabs(dy);
    in = h >= ((s.x0 < s.x1) ? s.x0 : s.x1) - 1 &&
         h <= ((s.x0 < s.x1) ? s.x1 : s.x0) + 1 &&
         v >= ((s.y0 < s.y1) ? s.y0 : s.y1) - 1 &&
         v <= ((s.y0 < s.y1) ? s.y1 : s.y0) + 1;
    return s.en && in && (iabs(cr) <= mx);
  endfunction

  function automatic logic [5:0] m_vec(input int h, input int v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i] = m_hit(m_act[i], h, v);
    return r;
  endfunction

  function automatic logic [11:0] m_color(input int h, input int v);
    logic [5:0] r;
    r = m_vec(h, v);
    for (int i = 0; i < 6; i++) if (r[i]) return PAL[i];
    return 12'h49C;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && q.size() == 4) begin
      e = q.pop_front();
      n_tot++;
      if (vga_valid === e.pv && vga_data === e.d && hit_vec === e.v)
        n_pass++;
      else
        $display("FAIL %s: got valid=%b data=%h vec=%b, want valid=%b data=%h vec=%b",
                 e.nm, vga_valid, vga_data, hit_vec, e.pv, e.d, e.v);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic tick(input bit pv, input int h, input int v,
                      input logic [11:0] d, input logic [5:0] vv,
                      input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    pix_valid = pv;
    h_cnt     = 10'(h);
    v_cnt     = 10'(v);
    e.pv = pv;
    e.d  = pv ? d : 12'h000;
    e.v  = pv ? vv : 6'b0;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 12'h000, 6'b0, "idle");
  endtask

  task automatic tickm(input int h, input int v, input string nm);
    tick(1'b1, h, v, m_color(h, v), m_vec(h, v), nm);
  endtask

  task automatic set_ld(input int idx, input bit en, input int x0,
                        input int y0, input int x1, input int y1);
    ld_idx = 4'(idx);
    ld_en  = en;
    ld_x0  = 12'(x0);
    ld_y0  = 12'(y0);
    ld_x1  = 12'(x1);
    ld_y1  = 12'(y1);
`ifdef LINE_COLOR_PROG_EN
    ld_color = PAL[idx % 6];
`endif
    ld_valid = 1'b1;
  endtask

  task automatic shadow_model(input int idx, input bit en, input int x0,
                              input int y0, input int x1, input int y1);
    if (idx < 6) begin
      m_sh[idx].en = en;
      m_sh[idx].x0 = x0;
      m_sh[idx].y0 = y0;
      m_sh[idx].x1 = x1;
      m_sh[idx].y1 = y1;
    end
  endtask

  task automatic load(input int idx, input bit en, input int x0,
                      input int y0, input int x1, input int y1);
    set_ld(idx, en, x0, y0, x1, y1);
    idle(1);
    ld_valid = 1'b0;
    shadow_model(idx, en, x0, y0, x1, y1);
  endtask

  task automatic commit();
    frame_start = 1'b1;
    for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
    idle(1);
    frame_start = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 6; i++) begin
      m_sh[i]  = '{1'b0, 0, 0, 0, 0};
      m_act[i] = '{1'b0, 0, 0, 0, 0};
    end
  endtask

  vec_t t1 [7];
  vec_t t2 [4];

  initial begin
    mseg_t s;
    int    h, v;

    t1[0] = '{150, 200, 1'b1, 12'hF00, 6'b000001, "t1_on_line"};
    t1[1] = '{150, 201, 1'b1, 12'hF00, 6'b000001, "t1_one_off"};
    t1[2] = '{150, 202, 1'b1, 12'h49C, 6'b000000, "t1_two_off"};
    t1[3] = '{301, 200, 1'b1, 12'hF00, 6'b000001, "t1_end_plus1"};
    t1[4] = '{302, 200, 1'b1, 12'h49C, 6'b000000, "t1_end_plus2"};
    t1[5] = '{ 99, 199, 1'b1, 12'hF00, 6'b000001, "t1_corner"};
    t1[6] = '{150, 200, 1'b0, 12'h000, 6'b000000, "t5_pix_invalid"};
    t2[0] = '{200, 200, 1'b1, 12'hF00, 6'b000011, "t2_cross"};
    t2[1] = '{200, 150, 1'b1, 12'h0F0, 6'b000010, "t2_vert_only"};
    t2[2] = '{201, 300, 1'b1, 12'h0F0, 6'b000010, "t2_vert_end"};
    t2[3] = '{202, 150, 1'b1, 12'h49C, 6'b000000, "t2_vert_miss"};

    clear_model();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_vga_data", 32'(vga_data), 32'h0);
    chk("rst_vga_valid", 32'(vga_valid), 32'h0);
    chk("rst_hit_vec", 32'(hit_vec), 32'h0);
    chk("rst_bad_idx", 32'(bad_idx), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("ld_ready_idle", 32'(ld_ready), 32'h1);
    mon_en = 1'b1;

    load(0, 1'b1, 100, 200, 300, 200);
    commit();
    foreach (t1[i]) tick(t1[i].pv, t1[i].h, t1[i].v, t1[i].d, t1[i].vec, t1[i].nm);

    load(1, 1'b1, 200, 100, 200, 300);
    commit();
    foreach (t2[i]) tick(t2[i].pv, t2[i].h, t2[i].v, t2[i].d, t2[i].vec, t2[i].nm);

    load(2, 1'b1, 400, 400, 500, 400);
    tick(1'b1, 450, 400, 12'h49C, 6'b0, "t3_pending");
    set_ld(3, 1'b1, 600, 100, 600, 110);
    frame_start = 1'b1;
    #1;
    chk("t3_ready_low_fs", 32'(ld_ready), 32'h0);
    for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
    idle(1);
    frame_start = 1'b0;
    #1;
    chk("t3_ready_after_fs", 32'(ld_ready), 32'h1);
    tick(1'b1, 450, 400, 12'h00F, 6'b000100, "t3_idx2_live");
    ld_valid = 1'b0;
    shadow_model(3, 1'b1, 600, 100, 600, 110);
    tick(1'b1, 600, 105, 12'h49C, 6'b0, "t3_idx3_not_active");

    chk("t4_bad_before", 32'(bad_idx), 32'h0);
    set_ld(7, 1'b1, 10, 10, 20, 10);
    #1;
    chk("t4_ready_bad_idx", 32'(ld_ready), 32'h1);
    idle(1);
    ld_valid = 1'b0;
    chk("t4_bad_set", 32'(bad_idx), 32'h1);
    load(4, 1'b1, 700, 300, 710, 300);
    load(4, 1'b1, 700, 320, 710, 320);
    commit();
    tick(1'b1, 15, 10, 12'h49C, 6'b0, "t4_dropped_geom");
    tick(1'b1, 600, 105, 12'hFF0, 6'b001000, "t3_idx3_late_load");
    tick(1'b1, 705, 300, 12'h49C, 6'b0, "dup_first_overwritten");
    tick(1'b1, 705, 320, 12'hF0F, 6'b010000, "dup_last_wins");

    for (int n = 0; n < 40; n++) begin
      s = m_act[$urandom_range(0, 4)];
      h = ((s.x0 < s.x1) ? s.x0 : s.x1) - 3 + int'($urandom_range(0, iabs(s.x1 - s.x0) + 6));
      v = ((s.y0 < s.y1) ? s.y0 : s.y1) - 3 + int'($urandom_range(0, iabs(s.y1 - s.y0) + 6));
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      tickm(h, v, "rand_model");
    end
    idle(4);
    chk("t4_bad_sticky", 32'(bad_idx), 32'h1);

    tick(1'b1, 150, 200, 12'hF00, 6'b000001, "pre_rst");
    tick(1'b1, 200, 150, 12'h0F0, 6'b000010, "pre_rst");
    #2;
    rst = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("t6_rst_vga_data", 32'(vga_data), 32'h0);
    chk("t6_rst_vga_valid", 32'(vga_valid), 32'h0);
    chk("t6_rst_hit_vec", 32'(hit_vec), 32'h0);
    chk("t6_rst_bad_idx", 32'(bad_idx), 32'h0);
    chk("t6_rst_ld_ready", 32'(ld_ready), 32'h0);
    q.delete();
    clear_model();
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    tick(1'b1, 150, 200, 12'h49C, 6'b0, "t6_post_rst_idx0");
    tick(1'b1, 200, 150, 12'h49C, 6'b0, "t6_post_rst_idx1");
    load(0, 1'b1, 50, 50, 50, 50);
    commit();
    tick(1'b1, 51, 51, 12'hF00, 6'b000001, "t6_degen_diag");
    tick(1'b1, 52, 50, 12'h49C, 6'b0, "t6_degen_far");
    tick(1'b1, 49, 49, 12'hF00, 6'b000001, "t6_degen_neg");
    tick(1'b1, 50, 50, 12'hF00, 6'b000001, "t6_degen_centre");
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/wireframe_line_renderer.md
Name: wireframe_line_renderer

Overview:
Parametrised successor to the fixed six-edge per-pixel line checker. It holds NUM_LINES screen-space line segments in double-buffered registers. Each streamed pixel coordinate is tested against every enabled segment in a 3-stage pipeline. The output is a 12-bit RGB colour chosen by fixed index priority. It sits between the vertex transform/projection stage, which feeds the load port, and the VGA timing generator, which feeds h_cnt/v_cnt.

Parameters:
NUM_LINES, 6, number of segments (1..16)
COORD_W, 12, signed integer width of endpoint coordinates
THICK, 1, line half-thickness in pixels (0..7)
IDX_W, 4, width of ld_idx

Ports:
CLK  in  1  system clock; one clock domain
rst  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse during vertical blanking; commits the shadow set to the active set
h_cnt  in  10  pixel x (unsigned)
v_cnt  in  10  pixel y (unsigned)
pix_valid  in  1  visible-area qualifier for h_cnt/v_cnt
ld_valid  in  1  load request
ld_ready  out  1  load accepted when ld_valid&&ld_ready
ld_idx  in  IDX_W  target segment index
ld_en  in  1  segment enable
ld_x0, ld_y0, ld_x1, ld_y1  in  COORD_W each  signed endpoints
vga_data  out  12  RGB444 pixel
vga_valid  out  1  delayed pix_valid
hit_vec  out  NUM_LINES  raw per-segment hits; bit i = segment i
bad_idx  out  1  sticky flag: a load targeted an index >= NUM_LINES

Behaviour:
- Reset (async, active-high) clears everything:
  - vga_data=0, vga_valid=0, hit_vec=0, bad_idx=0.
  - All shadow and active segments cleared, enables=0.
  - ld_ready=0 while rst is high.
- Reset mid-frame: in-flight pipeline data is discarded. After rst deasserts, valid pixels show background until a commit occurs.
- Load handshake:
  - ld_ready = !rst && !frame_start.
  - A transfer writes the shadow entry ld_idx only. The active set is unchanged.
  - Same ld_idx loaded twice before a commit: last write wins.
  - ld_idx >= NUM_LINES: the transfer completes, its data is dropped, and bad_idx is set until reset.
- Commit: on frame_start, active <= shadow, all entries in one cycle. A pixel entering S1 on the same cycle still uses the old set. The new set applies from the next cycle.
- Pipeline, latency exactly 3 cycles from pix_valid/h_cnt/v_cnt to vga_valid/vga_data/hit_vec:
  - S1: per segment, register dx=x1-x0, dy=y1-y0, px=h-x0, py=v-y0 (COORD_W+1 bits, signed; h/v zero-extended). Also register the bounding box expanded by THICK.
  - S2: register cross = dx*py - dy*px (2*COORD_W+3 bits) and the bbox-inside bit.
  - S3: register hit_i = en_i && inside_i && |cross| <= THICK*max(|dx|,|dy|).
- Degenerate segment (dx=dy=0): the hit rule reduces to a bbox test, i.e. Chebyshev distance <= THICK from the point.
- Colour selection:
  - The lowest hit index wins.
  - Palette by index mod 6: F00, 0F0, 00F, FF0, F0F, 0FF.
  - No hit: background 49C.
  - Registered pix_valid=0 forces vga_data=000 and hit_vec=0.
- No backpressure on the pixel stream. Overflow is impossible because all arithmetic is full-width.

Optional Feature:
LINE_COLOR_PROG_EN
- Defined:
  - Adds input ld_color[11:0]; each shadow entry also stores a 12-bit colour, committed with the geometry.
  - Reset colour is palette[idx mod 6].
  - Hit colour comes from the active colour register.
- Undefined: no ld_color port; fixed palette only. Timing and latency are identical either way.

Decomposition:
- Package render_pkg holds:
  - the palette constant array and BG_COLOR=12'h49C;
  - BLANK_COLOR=12'h000;
  - the segment record type {en, x0, y0, x1, y1[, color]}.
- Sub-module line_hit_unit: the per-segment S1–S3 datapath, producing a 1-bit hit. It is instantiated NUM_LINES times by generate.
- The top level holds the shadow/active register banks, load handshake, priority encoder and output registers.

Test Plan:
1. Load idx0 = (100,200)-(300,200), en=1, then frame_start; pixels (150,200) and (150,201) -> F00 at +3 cycles; (150,202) -> 49C; (301,200) -> F00; (302,200) -> 49C.
2. Add idx1 = (200,100)-(200,300), commit; pixel (200,200) -> hit_vec=6'b000011, vga_data=F00; (200,150) -> 0F0.
3. Load idx2 without frame_start -> no hits on idx2 geometry. After frame_start, the next pixel entering S1 hits. A ld_valid held during the frame_start cycle sees ld_ready=0 and completes one cycle later.
4. ld_idx=7 with NUM_LINES=6 -> transfer completes, bad_idx=1 stays set, the active set is unchanged.
5. pix_valid=0 for a segment-hit coordinate -> vga_data=000, vga_valid=0 three cycles later.
6. Assert rst for 2 cycles mid-line -> outputs 0 immediately. Post-reset valid pixels on former segments -> 49C. Degenerate segment (50,50)-(50,50) with THICK=1 -> (51,51) hit, (52,50) miss.
